// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Ports: clk, rst (sync, active high); start/op/a/b request; abort cancels;
//        busy high during CALC/FIX; done pulses when hi/lo take a result; hi/lo architectural regs.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state_q, state_d;
    logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic a_neg, b_neg, div_ge;
    logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
    logic [WIDTH:0] mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    // divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign div_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_ge = ~div_diff[WIDTH];
    assign div_step = {div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo = acc_q[WIDTH-1:0];
    assign rem = acc_q[2*WIDTH-1:WIDTH];
    always_comb begin
        state_d = state_q;
        div_d = div_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        cnt_d = cnt_q;
        opb_d = opb_q;
        acc_d = acc_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (start && !op[2]) begin
                state_d = CALC;
                div_d = op[1];
                // divide by zero keeps the raw all-ones quotient, so no sign fix there
                neg_d = (a_neg ^ b_neg) & (~op[1] | (|b));
                rneg_d = a_neg;
                cnt_d = '0;
                opb_d = op[1] ? b_mag : a_mag;
                acc_d = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            end
            hi_d = (start && op == 3'b100) ? a : hi_q;
            lo_d = (start && op == 3'b101) ? a : lo_q;
        end else if (state_q == CALC) begin
            acc_d = div_q ? div_step : mul_step;
            cnt_d = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
        end else begin
            state_d = IDLE;
            done_d = 1'b1;
            hi_d = div_q ? (rneg_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
            lo_d = div_q ? (neg_q ? -quo : quo) : prod[WIDTH-1:0];
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            cnt_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            cnt_q <= cnt_d;
            opb_q <= opb_d;
            acc_q <= acc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, the sequential companion to the single-cycle ALU in the MIPS execute stage. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO over a parametrised operand width. It uses a start/busy/done handshake so the pipeline control can stall on HI/LO hazards. An abort input lets a pipeline flush cancel an in-flight operation.

## Interface
- WIDTH, 32, operand and HI/LO width in bits; legal values are 4 or more.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- b  in  WIDTH  rt operand: multiplier or divisor.
- abort  in  1  cancels any operation in progress.
- busy  out  1  high while a MULT/DIV is in progress.
- done  out  1  one-cycle pulse when HI/LO have just been updated by a MULT/DIV.
- hi  out  WIDTH  HI register; also carries the remainder.
- lo  out  WIDTH  LO register; also carries the quotient.

## Operation
- States: IDLE, CALC, FIX.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- IDLE behaviour:
  - start=1 with MULT/MULTU/DIV/DIVU: latch op, latch operand magnitudes (signed ops take |a| and |b|; a result sign flag records the required sign), clear counter, go to CALC.
  - start=1 with MTHI: hi<=a at that edge. MTLO: lo<=a at that edge. Neither changes busy or done; state stays IDLE.
  - start=1 with op 110 or 111: no effect.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- CALC lasts exactly WIDTH cycles, then the unit goes to FIX.
- FIX: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Arithmetic rules:
  - Multiply results: hi = upper WIDTH bits, lo = lower WIDTH bits of the full 2*WIDTH product. MULT is two's-complement signed; MULTU is unsigned.
  - DIV quotient truncates toward zero. The remainder takes the dividend's sign. Invariant: a = lo*b + hi.
  - DIV overflow (a = most negative value, b = -1): lo = a, hi = 0. This is the natural result of the magnitude algorithm and must not be special-cased into anything else.
  - Divide by zero (DIV or DIVU, b=0): lo = all ones, hi = a unchanged. The full WIDTH cycles are still taken.
- Boundary behaviour:
  - start while busy: ignored, with no queueing.
  - Operand inputs are not required to be stable after the start edge.
  - abort=1 in CALC or FIX: go to IDLE at that edge. hi/lo are unchanged, done stays 0 and busy drops next cycle.
  - abort has priority over everything, including a same-cycle start in IDLE (start is dropped, MTHI/MTLO included).
  - rst in any state: return to reset values at that edge; rst beats abort and start.
  - A new start is accepted in the cycle immediately after the done pulse.

## Timing
- Let the start edge be edge 0.
- busy is high after edge 0 through the FIX cycle, i.e. for WIDTH+1 cycles.
- After edge WIDTH+1: hi/lo hold the result, done=1 for one cycle, busy=0.
- Latency from start to result is WIDTH+1 cycles (33 at WIDTH=32), fixed and independent of operand values.
- MTHI/MTLO: the value is visible on hi/lo the cycle after the start edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios at WIDTH=32.
- MULT, a=0xFFFFFFFD (-3), b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done high for exactly one cycle, busy high for 33 cycles.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands -> hi=0, lo=1.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV, a=7, b=-2 -> lo=0xFFFFFFFD, hi=1. DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, a=7, b=0 -> lo=0xFFFFFFFF, hi=7 after 33 cycles. DIVU, a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0xF.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 each one cycle after its start edge, with no busy or done. Then start MULT, pulse abort at cycle 10 -> busy low next cycle, hi/lo still 0x1234/0x5678, no done.
- Protocol checks:
  - start asserted every cycle during a DIV -> only the first is accepted.
  - start + abort in the same IDLE cycle -> nothing happens.
  - rst mid-CALC -> hi=lo=0, busy=0 after that edge.
  - Random signed and unsigned operands against a reference model satisfy a = lo*b + hi and the full-product equation.
